// File: rtl/closest_hit_resolver_pkg.sv
// closest_hit_resolver_pkg: shared hit types (Fixed, HitData, SurfaceType, primitive index) for the resolver
package closest_hit_resolver_pkg;
    typedef logic signed [31:0] fixed_t;
    localparam int PRIMITIVE_INDEX_W = 16;
    typedef logic [PRIMITIVE_INDEX_W-1:0] primitive_index_t;
    localparam primitive_index_t NULL_PRIMITIVE_INDEX = '1;
    typedef enum logic [1:0] {ST_None, ST_Diffuse, ST_Mirror, ST_Glass} surface_type_e;
    typedef struct packed {
        logic             b_hit;
        primitive_index_t pi;
        logic [23:0]      color;
        fixed_t           t;
        surface_type_e    surface_type;
        logic [47:0]      normal;
    } hit_data_t;
    function automatic hit_data_t miss_record(fixed_t t);
        hit_data_t m;
        m = '0;
        m.pi = NULL_PRIMITIVE_INDEX;
        m.surface_type = ST_None;
        m.t = t;
        return m;
    endfunction
endpackage

// File: rtl/closest_hit_resolver_fixed_less.sv
// fixed_less: signed Fixed compare, lt = a < b
import closest_hit_resolver_pkg::*;
module fixed_less (
    input  fixed_t a,
    input  fixed_t b,
    output logic   lt
);
    assign lt = a < b;
endmodule

// File: rtl/closest_hit_resolver.sv
// closest_hit_resolver: keeps the nearest accepted hit of a ray's beat stream and emits it (or a miss)
import closest_hit_resolver_pkg::*;
module closest_hit_resolver (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  fixed_t      t_min,
    input  fixed_t      t_max,
    input  logic        hit_valid,
    output logic        hit_ready,
    input  hit_data_t   hit_in,
    input  logic        hit_last,
    output logic        out_valid,
    input  logic        out_ready,
    output hit_data_t   out_hit,
    output logic [15:0] out_beats,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;
    state_e state, state_n;
    fixed_t t_min_q;
    logic fire, below_min, closer, take;
    assign hit_ready = state == SCAN;
    assign out_valid = state == EMIT;
    assign busy      = state != IDLE;
    assign fire      = hit_valid && hit_ready;
    // out_hit doubles as the running best, so its T is the strict upper bound (t_max until a hit lands)
    fixed_less u_min_chk  (.a(hit_in.t), .b(t_min_q),   .lt(below_min));
    fixed_less u_best_chk (.a(hit_in.t), .b(out_hit.t), .lt(closer));
    assign take = hit_in.b_hit && !below_min && closer;
    always_comb begin
        state_n = (state == IDLE && start)             ? SCAN :
                  (state == SCAN && fire && hit_last)  ? EMIT :
                  (state == EMIT && out_ready)         ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            t_min_q   <= '0;
            out_hit   <= miss_record('0);
            out_beats <= '0;
        end else if (state == IDLE && start) begin
            t_min_q   <= t_min;
            out_hit   <= miss_record(t_max);
            out_beats <= '0;
        end else if (fire) begin
            if (take) out_hit <= hit_in;
            out_beats <= (out_beats == 16'hFFFF) ? out_beats : out_beats + 16'd1;
        end
    end
endmodule

// File: tb/tb_closest_hit_resolver.sv
// tb_closest_hit_resolver: scoreboard bench for the closest-hit resolver
import closest_hit_resolver_pkg::*;
module tb_closest_hit_resolver;
    logic clk = 0, reset = 1, start = 0, hit_valid = 0, hit_last = 0, out_ready = 0;
    fixed_t t_min = 0, t_max = 0;
    hit_data_t hit_in = '0, out_hit;
    logic hit_ready, out_valid, busy;
    logic [15:0] out_beats;
    int n_cmp = 0, n_err = 0;
    hit_data_t exp_hit_q[$];
    int exp_beats_q[$];
    fixed_t m_tmin;
    hit_data_t m_best;
    int m_beats;

    closest_hit_resolver dut (
        .clk(clk), .reset(reset), .start(start), .t_min(t_min), .t_max(t_max),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_in(hit_in), .hit_last(hit_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .out_beats(out_beats), .busy(busy)
    );
    always #5 clk = ~clk;

    function automatic fixed_t fx(int v);
        return fixed_t'(v) <<< 16;
    endfunction
    function automatic hit_data_t mk_hit(logic b, int pi, fixed_t t);
        hit_data_t h;
        h.b_hit = b;
        h.pi = primitive_index_t'(pi);
        h.color = 24'(pi * 24'h010203 + 24'h112233);
        h.t = t;
        h.surface_type = ST_Diffuse;
        h.normal = {16'(pi), 16'hA5A5, 16'(pi + 1)};
        return h;
    endfunction
    function automatic hit_data_t exp_miss(fixed_t t);
        hit_data_t h;
        h = '0;
        h.pi = NULL_PRIMITIVE_INDEX;
        h.surface_type = ST_None;
        h.t = t;
        return h;
    endfunction

    task automatic start_ray(fixed_t lo, fixed_t hi);
        start = 1; t_min = lo; t_max = hi;
        m_tmin = lo; m_best = exp_miss(hi); m_beats = 0;
        @(posedge clk); #1;
        start = 0;
    endtask
    task automatic send_beat(hit_data_t h, logic last);
        hit_valid = 1; hit_in = h; hit_last = last;
        @(posedge clk); #1;
        hit_valid = 0; hit_last = 0; hit_in = mk_hit(1'b1, 99, fx(-50));
        if (h.b_hit && h.t >= m_tmin && h.t < m_best.t) m_best = h;
        if (m_beats < 65535) m_beats++;
        if (last) begin
            exp_hit_q.push_back(m_best);
            exp_beats_q.push_back(m_beats);
        end
    endtask
    task automatic wait_out(output logic ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (out_valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask
    task automatic accept_out();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask
    task automatic check_result(string name);
        logic ok;
        hit_data_t eh;
        int eb;
        wait_out(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
            return;
        end
        eh = exp_hit_q.pop_front();
        eb = exp_beats_q.pop_front();
        n_cmp++;
        if (out_hit !== eh) begin
            n_err++;
            $display("FAIL %s out_hit: got %h required %h", name, out_hit, eh);
        end
        n_cmp++;
        if (out_beats !== 16'(eb)) begin
            n_err++;
            $display("FAIL %s out_beats: got %0d required %0d", name, out_beats, eb);
        end
        accept_out();
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s return_idle: busy=%b out_valid=%b required 0/0", name, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({hit_ready, out_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctl: hit_ready/out_valid/busy=%b required 000", {hit_ready, out_valid, busy});
        end
        n_cmp++;
        if (out_beats !== 16'd0 || out_hit !== exp_miss(0)) begin
            n_err++;
            $display("FAIL reset_data: beats=%0d hit=%h required 0 %h", out_beats, out_hit, exp_miss(0));
        end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_closest();
        start_ray(fx(0), fx(100));
        n_cmp++;
        if (hit_ready !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL scan_ready: hit_ready=%b busy=%b required 1/1", hit_ready, busy);
        end
        send_beat(mk_hit(1, 3, fx(5)), 0);
        send_beat(mk_hit(1, 7, fx(2)), 0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL closest_early_valid: out_valid=%b required 0", out_valid);
        end
        send_beat(mk_hit(1, 1, fx(9)), 1);
        n_cmp++;
        if (out_valid !== 1'b1 || hit_ready !== 1'b0) begin
            n_err++;
            $display("FAIL closest_latency: out_valid=%b hit_ready=%b required 1/0", out_valid, hit_ready);
        end
        check_result("closest");
    endtask

    task automatic test_miss();
        start_ray(fx(0), fx(100));
        send_beat(mk_hit(0, 4, fx(1)), 0);
        send_beat(mk_hit(1, 6, fx(-1)), 0);
        send_beat(mk_hit(0, 8, fx(3)), 1);
        check_result("miss");
    endtask

    task automatic test_tie_hold();
        hit_data_t eh;
        start_ray(fx(0), fx(100));
        send_beat(mk_hit(1, 2, fx(4)), 0);
        send_beat(mk_hit(1, 5, fx(4)), 1);
        eh = exp_hit_q[0];
        for (int i = 0; i < 5; i++) begin
            start = 1; t_max = fx(1); hit_valid = 1; hit_in = mk_hit(1, 9, fx(0));
            @(posedge clk); #1;
            start = 0; hit_valid = 0;
            n_cmp++;
            if (out_valid !== 1'b1 || out_hit !== eh || out_beats !== 16'd2) begin
                n_err++;
                $display("FAIL tie_hold cycle %0d: valid=%b hit=%h beats=%0d required 1 %h 2", i, out_valid, out_hit, out_beats, eh);
            end
        end
        check_result("tie");
    endtask

    task automatic test_reset_mid_scan();
        start_ray(fx(0), fx(100));
        send_beat(mk_hit(1, 11, fx(1)), 0);
        send_beat(mk_hit(1, 12, fx(1)), 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        n_cmp++;
        if (busy !== 1'b0 || hit_ready !== 1'b0 || out_beats !== 16'd0) begin
            n_err++;
            $display("FAIL abort: busy=%b hit_ready=%b beats=%0d required 0 0 0", busy, hit_ready, out_beats);
        end
        start_ray(fx(0), fx(50));
        send_beat(mk_hit(1, 13, fx(60)), 0);
        send_beat(mk_hit(0, 14, fx(30)), 1);
        check_result("after_abort");
    endtask

    task automatic test_saturate();
        start_ray(fx(0), fx(100));
        hit_valid = 1; hit_last = 0; hit_in = mk_hit(0, 0, fx(1));
        repeat (70000) @(posedge clk);
        #1;
        m_beats = 65535;
        send_beat(mk_hit(0, 0, fx(1)), 1);
        check_result("saturate");
    endtask

    task automatic test_inverted_bounds();
        start_ray(fx(10), fx(5));
        send_beat(mk_hit(1, 21, fx(7)), 1);
        check_result("inverted");
    endtask

    task automatic test_back_to_back();
        start_ray(fx(-20), fx(20));
        send_beat(mk_hit(1, 31, fx(-3)), 0);
        send_beat(mk_hit(1, 32, fx(-25)), 0);
        send_beat(mk_hit(1, 33, fx(-7)), 1);
        check_result("b2b_a");
        start_ray(fx(0), fx(100));
        for (int i = 0; i < 8; i++)
            send_beat(mk_hit(1'($urandom_range(0, 1)), 40 + i, fx($urandom_range(0, 120) - 10)), i == 7);
        check_result("b2b_rand");
    endtask

    initial begin
        test_reset();
        test_closest();
        test_miss();
        test_tie_hold();
        test_reset_mid_scan();
        test_inverted_bounds();
        test_back_to_back();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
